// File: rtl/signal_period_meter.sv
// Measures period and high time of an asynchronous square wave between rising edges,
// in clk cycles, and flags loss of signal after TIMEOUT cycles without a rising edge.
module signal_period_meter #(
    parameter int CNT_W   = 27,
    parameter int TIMEOUT = 100000000
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             timeout
);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    state_t           state_q, state_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic             rise;

    assign rise = sync2_q & ~prev_q;

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            prev_q      <= 1'b0;
            cnt_q       <= '0;
            hi_cnt_q    <= '0;
            period_q    <= '0;
            high_time_q <= '0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            cnt_q       <= cnt_d;
            hi_cnt_q    <= hi_cnt_d;
            period_q    <= period_d;
            high_time_q <= high_time_d;
            valid_q     <= valid_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        sync1_d     = sig_in;
        sync2_d     = sync1_q;
        prev_d      = sync2_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_cnt_d    = hi_cnt_q;
        period_d    = period_q;
        high_time_d = high_time_q;
        valid_d     = 1'b0;
        timeout_d   = timeout_q;

        // Disabling abandons the running interval but keeps the last reported results.
        if (!enable) begin
            state_d  = IDLE;
            cnt_d    = '0;
            hi_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d  = MEASURE;
                        cnt_d    = ONE_C;
                        hi_cnt_d = ONE_C;
                    end
                end
                MEASURE: begin
                    // A rise landing exactly on the timeout count still closes the interval.
                    if (rise) begin
                        period_d    = cnt_q;
                        high_time_d = hi_cnt_q;
                        valid_d     = 1'b1;
                        timeout_d   = 1'b0;
                        cnt_d       = ONE_C;
                        hi_cnt_d    = ONE_C;
                    end else if (cnt_q == TIMEOUT_C) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                        cnt_d     = '0;
                        hi_cnt_d  = '0;
                    end else begin
                        cnt_d    = cnt_q + ONE_C;
                        hi_cnt_d = hi_cnt_q + {{(CNT_W-1){1'b0}}, sync2_q};
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign period    = period_q;
    assign high_time = high_time_q;
    assign valid     = valid_q;
    assign timeout   = timeout_q;

endmodule
